// File: rtl/irq_pkg.sv
// Interrupt controller shared types: source indices, vector layout, FSM states.
// Imported by irq_flag_bit and irq_ctrl.
package irq_pkg;

  typedef enum logic [2:0] {
    SRC_VBLANK = 3'd0,
    SRC_STAT   = 3'd1,
    SRC_TIMER  = 3'd2,
    SRC_SERIAL = 3'd3,
    SRC_JOYPAD = 3'd4
  } irq_src_e;

  localparam int          NUM_SRC    = 5;
  localparam logic [15:0] VEC_BASE   = 16'h0040;
  localparam logic [15:0] VEC_STRIDE = 16'd8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W1      = 3'd1,
    W2      = 3'd2,
    PUSH_HI = 3'd3,
    PUSH_LO = 3'd4,
    JUMP    = 3'd5
  } irq_state_e;

  function automatic logic [15:0] vec_of(irq_src_e s);
    return VEC_BASE + VEC_STRIDE * {13'd0, s};
  endfunction

endpackage

// File: rtl/irq_flag_bit.sv
// One IF bit: rising-edge detect on its source, set-dominant over CPU write and clear.
// Ports: clk, reset, src (request line), wr/wbit (CPU write), clr (dispatch ack), flag.
module irq_flag_bit
  import irq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic wr,
  input  logic wbit,
  input  logic clr,
  output logic flag
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      flag <= 1'b0;
    end else begin
      prev <= src;
      if (src && !prev)
        flag <= 1'b1;
      else if (wr)
        flag <= wbit;
      else if (clr)
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: IF/IE registers, IME with delayed EI, and dispatch FSM.
// Ports: clk, reset, m_tick, irq_src, wr_if/wr_ie/wdata, rdata_if/rdata_ie,
//        ei/di/reti/instr_done, disp_start, int_req, wake, disp_busy, vec_valid, vector.
module irq_ctrl
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m_tick,
  input  logic [4:0]  irq_src,
  input  logic        wr_if,
  input  logic        wr_ie,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata_if,
  output logic [7:0]  rdata_ie,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_done,
  input  logic        disp_start,
  output logic        int_req,
  output logic        wake,
  output logic        disp_busy,
  output logic        vec_valid,
  output logic [15:0] vector
);

  logic [4:0] if_q;
  logic [4:0] clr;
  logic [4:0] pend;
  logic [7:0] ie_q;
  logic       ime;
  logic       arm;
  logic       arm_cnt;
  logic       fire;
  logic       go;
  logic       resolve;
  logic       hit;
  irq_src_e   sel;
  irq_state_e state;
  irq_state_e state_nx;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_flag
    irq_flag_bit u_flag (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[g]),
      .wr    (wr_if),
      .wbit  (wdata[g]),
      .clr   (clr[g]),
      .flag  (if_q[g])
    );
  end

  assign pend      = if_q & ie_q[4:0];
  assign wake      = |pend;
  assign disp_busy = (state != IDLE);
  assign vec_valid = (state == JUMP);
  assign int_req   = ime & wake & ~disp_busy;
  assign rdata_if  = {3'b111, if_q};
  assign rdata_ie  = ie_q;

  // Descending scan so the lowest pending index is the one kept.
  always_comb begin
    sel = SRC_VBLANK;
    hit = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel = irq_src_e'(3'(i));
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    resolve  = 1'b0;
    if (m_tick) begin
      unique case (state)
        IDLE: begin
          if (disp_start) begin
            state_nx = W1;
            go       = 1'b1;
          end
        end
        W1:      state_nx = W2;
        W2:      state_nx = PUSH_HI;
        PUSH_HI: state_nx = PUSH_LO;
        PUSH_LO: begin
          state_nx = JUMP;
          resolve  = 1'b1;
        end
        JUMP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign clr = (resolve && hit) ? (5'd1 << sel) : 5'd0;

  // The instr_done that completes the EI instruction itself is the first;
  // IME turns on after the second one.
  assign fire = !ei && instr_done && arm && arm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q    <= 8'h00;
      vector  <= 16'h0000;
      ime     <= 1'b0;
      arm     <= 1'b0;
      arm_cnt <= 1'b0;
    end else begin
      if (wr_ie)
        ie_q <= wdata;
      if (resolve)
        vector <= hit ? vec_of(sel) : 16'h0000;
      if (di) begin
        ime     <= 1'b0;
        arm     <= 1'b0;
        arm_cnt <= 1'b0;
      end else begin
        if (go)
          ime <= 1'b0;
        else if (reti || fire)
          ime <= 1'b1;
        if (ei) begin
          arm     <= 1'b1;
          arm_cnt <= 1'b0;
        end else if (instr_done && arm) begin
          if (arm_cnt) begin
            arm     <= 1'b0;
            arm_cnt <= 1'b0;
          end else begin
            arm_cnt <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios then random traffic against
// a reference model; dispatch vectors are checked through a scoreboard queue.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_tick = 1'b0;
  logic [4:0]  irq_src = 5'd0;
  logic        wr_if = 1'b0;
  logic        wr_ie = 1'b0;
  logic [7:0]  wdata = 8'd0;
  logic [7:0]  rdata_if;
  logic [7:0]  rdata_ie;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        reti = 1'b0;
  logic        instr_done = 1'b0;
  logic        disp_start = 1'b0;
  logic        int_req;
  logic        wake;
  logic        disp_busy;
  logic        vec_valid;
  logic [15:0] vector;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  logic [4:0]  m_prev;
  logic        m_ime;
  int          m_left;
  int          m_phase;
  logic [15:0] exp_q[$];
  logic [15:0] cur_vec;
  logic        in_jump = 1'b0;

  irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .m_tick     (m_tick),
    .irq_src    (irq_src),
    .wr_if      (wr_if),
    .wr_ie      (wr_ie),
    .wdata      (wdata),
    .rdata_if   (rdata_if),
    .rdata_ie   (rdata_ie),
    .ei         (ei),
    .di         (di),
    .reti       (reti),
    .instr_done (instr_done),
    .disp_start (disp_start),
    .int_req    (int_req),
    .wake       (wake),
    .disp_busy  (disp_busy),
    .vec_valid  (vec_valid),
    .vector     (vector)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_if    = 5'd0;
    m_ie    = 8'd0;
    m_prev  = 5'd0;
    m_ime   = 1'b0;
    m_left  = 0;
    m_phase = 0;
  endtask

  // Dispatch is modelled as a count of m_ticks since acceptance:
  // 0 idle, 1..4 wait/push cycles, 5 = vector presented.
  task automatic model_step();
    logic [4:0] rise;
    logic [4:0] pend;
    logic [4:0] clr;
    logic       go;
    logic       fire;
    int         n;
    rise   = irq_src & ~m_prev;
    m_prev = irq_src;
    pend   = m_if & m_ie[4:0];
    clr    = 5'd0;
    if (m_tick && m_phase == 4) begin
      n = -1;
      for (int i = 0; i < 5; i++)
        if (pend[i] && n < 0) n = i;
      if (n >= 0) begin
        clr[n] = 1'b1;
        exp_q.push_back(16'h0040 + 16'(8 * n));
      end else begin
        exp_q.push_back(16'h0000);
      end
    end
    go = m_tick && m_phase == 0 && disp_start;
    if (m_tick) begin
      if (go) m_phase = 1;
      else if (m_phase != 0) m_phase = (m_phase + 1) % 6;
    end
    for (int i = 0; i < 5; i++)
      m_if[i] = rise[i] ? 1'b1 : wr_if ? wdata[i] : clr[i] ? 1'b0 : m_if[i];
    if (wr_ie) m_ie = wdata;
    if (di) begin
      m_ime  = 1'b0;
      m_left = 0;
    end else begin
      fire = !ei && instr_done && m_left == 1;
      if (go) m_ime = 1'b0;
      else if (reti || fire) m_ime = 1'b1;
      if (ei) m_left = 2;
      else if (instr_done && m_left > 0) m_left = m_left - 1;
    end
  endtask

  task automatic compare_all();
    logic w;
    w = |(m_if & m_ie[4:0]);
    chk("rdata_if", rdata_if, {3'b111, m_if});
    chk("rdata_ie", rdata_ie, m_ie);
    chk("wake", wake, w);
    chk("disp_busy", disp_busy, m_phase != 0);
    chk("int_req", int_req, m_ime && w && m_phase == 0);
    chk("vec_valid", vec_valid, m_phase == 5);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    m_tick     = 1'b0;
    disp_start = 1'b0;
    wr_if      = 1'b0;
    wr_ie      = 1'b0;
    ei         = 1'b0;
    di         = 1'b0;
    reti       = 1'b0;
    instr_done = 1'b0;
  endtask

  task automatic tickn(int k);
    for (int i = 0; i < k; i++) begin
      m_tick = 1'b1;
      cyc();
    end
  endtask

  task automatic start_disp();
    m_tick     = 1'b1;
    disp_start = 1'b1;
    cyc();
  endtask

  always @(negedge clk) begin
    if (vec_valid) begin
      if (!in_jump) begin
        if (exp_q.size() == 0) begin
          chk("vec_unexpected", vector, 16'hxxxx);
          cur_vec = vector;
        end else begin
          cur_vec = exp_q.pop_front();
        end
        in_jump = 1'b1;
      end
      chk("vector", vector, cur_vec);
    end else begin
      in_jump = 1'b0;
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdata_if", rdata_if, 8'hE0);
    chk("rst_rdata_ie", rdata_ie, 8'h00);
    chk("rst_int_req", int_req, 1'b0);
    chk("rst_wake", wake, 1'b0);
    chk("rst_busy", disp_busy, 1'b0);
    chk("rst_vec_valid", vec_valid, 1'b0);
    chk("rst_vector", vector, 16'h0000);
    reset = 1'b0;

    wr_ie = 1'b1; wdata = 8'h05; cyc();
    irq_src = 5'b00100; cyc();
    irq_src = 5'b00000; cyc();
    chk("t34_if", rdata_if, 8'hE4);
    chk("t34_wake", wake, 1'b1);
    chk("t34_int_req", int_req, 1'b0);

    wr_if = 1'b1; wdata = 8'h05; cyc();
    wr_ie = 1'b1; wdata = 8'h1F; cyc();
    ei = 1'b1; cyc();
    instr_done = 1'b1; cyc();
    chk("t35_not_yet", int_req, 1'b0);
    instr_done = 1'b1; cyc();
    chk("t35_int_req", int_req, 1'b1);
    start_disp();
    chk("t35_busy", disp_busy, 1'b1);
    tickn(4);
    chk("t35_vector", vector, 16'h0040);
    chk("t35_if", rdata_if, 8'hE4);
    tickn(1);
    chk("t35_ime_clr", int_req, 1'b0);

    start_disp();
    tickn(1);
    wr_if = 1'b1; wdata = 8'h00; cyc();
    tickn(3);
    chk("t36_valid", vec_valid, 1'b1);
    chk("t36_vector", vector, 16'h0000);
    chk("t36_if", rdata_if, 8'hE0);
    tickn(1);

    irq_src = 5'b00001; wr_if = 1'b1; wdata = 8'h00; cyc();
    chk("t37_if", rdata_if, 8'hE1);
    irq_src = 5'b00000;

    ei = 1'b1; cyc();
    instr_done = 1'b1; cyc();
    di = 1'b1; cyc();
    instr_done = 1'b1; cyc();
    instr_done = 1'b1; cyc();
    chk("t38_int_req", int_req, 1'b0);

    reti = 1'b1; cyc();
    chk("reti_int_req", int_req, 1'b1);
    di = 1'b1; cyc();

    wr_if = 1'b1; wdata = 8'h08; cyc();
    start_disp();
    tickn(2);
    chk("t39_busy_before", disp_busy, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("t39_if", rdata_if, 8'hE0);
    chk("t39_busy", disp_busy, 1'b0);
    chk("t39_vec_valid", vec_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      m_tick     = ($urandom_range(0, 1) == 1);
      disp_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) irq_src = 5'($urandom);
      wr_if      = ($urandom_range(0, 15) == 0);
      wr_ie      = ($urandom_range(0, 31) == 0);
      wdata      = 8'($urandom);
      ei         = ($urandom_range(0, 9) == 0);
      di         = ($urandom_range(0, 29) == 0);
      reti       = ($urandom_range(0, 29) == 0);
      instr_done = ($urandom_range(0, 2) == 0);
      cyc();
    end
    tickn(8);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The module SHALL expose: clk  in  1  system clock, all state on rising edge.
REQ-002 The module SHALL expose: reset  in  1  asynchronous, active-high reset.
REQ-003 The module SHALL expose: m_tick  in  1  one-clk strobe marking each M-cycle boundary.
REQ-004 The module SHALL expose: irq_src  in  5  request lines [0]=vblank [1]=stat [2]=timer [3]=serial [4]=joypad.
REQ-005 The module SHALL expose: wr_if, wr_ie  in  1 each  CPU write strobes for IF (FF0F) and IE (FFFF).
REQ-006 The module SHALL expose: wdata  in  8  CPU write data.
REQ-007 The module SHALL expose: rdata_if, rdata_ie  out  8 each  register read values.
REQ-008 The module SHALL expose: ei, di, reti, instr_done  in  1 each  CPU strobes, one clk wide.
REQ-009 The module SHALL expose: disp_start  in  1  CPU begins interrupt dispatch.
REQ-010 The module SHALL expose: int_req, wake, disp_busy, vec_valid  out  1 each; vector  out  16.

Function
REQ-011 IF[4:0] SHALL set on a rising edge of irq_src[n], sampled each clk.
REQ-012 wr_if SHALL load IF[4:0] from wdata[4:0]; rdata_if[7:5] SHALL read 1.
REQ-013 Source edge and wr_if on the same bit in the same clk: set SHALL win.
REQ-014 wr_ie SHALL load all 8 IE bits; rdata_ie SHALL return them unchanged.
REQ-015 pend = IF[4:0] & IE[4:0]; wake SHALL equal |pend, independent of IME.
REQ-016 int_req SHALL equal IME & |pend & !disp_busy, combinational.
REQ-017 di SHALL clear IME and cancel any armed EI in the same clk.
REQ-018 ei SHALL arm; IME SHALL set on the second instr_done after ei (i.e. after the following instruction).
REQ-019 reti SHALL set IME in the next clk, no delay.
REQ-020 FSM states: IDLE, W1, W2, PUSH_HI, PUSH_LO, JUMP; advances only on m_tick.
REQ-021 disp_start in IDLE SHALL enter W1, clear IME, assert disp_busy until IDLE.
REQ-022 W1->W2->PUSH_HI->PUSH_LO->JUMP on successive m_tick; JUMP->IDLE on next m_tick.
REQ-023 At the m_tick leaving PUSH_LO, the lowest set bit n of pend SHALL be resolved and IF[n] cleared.
REQ-024 vector SHALL be 0x0040 + 8*n; if pend is zero at resolution, vector SHALL be 0x0000 and no IF bit cleared.
REQ-025 vec_valid SHALL be high exactly while in JUMP; vector SHALL hold constant in JUMP.
REQ-026 Sources setting IF after resolution SHALL remain pending for a later dispatch.
REQ-027 disp_start outside IDLE SHALL be ignored; ei/di during dispatch SHALL apply normally.

Reset
REQ-028 Reset SHALL force IF=0, IE=0, IME=0, EI-arm=0, state=IDLE, edge history=current irq_src image taken as 0.
REQ-029 Reset SHALL force outputs: rdata_if=0xE0, rdata_ie=0x00, int_req=0, wake=0, disp_busy=0, vec_valid=0, vector=0x0000.
REQ-030 Reset asserted mid-dispatch SHALL abort immediately to IDLE with no IF bit cleared.

Structure
REQ-031 Package irq_pkg SHALL hold source-index enum, vector base 0x0040 and stride 8, and FSM state enum.
REQ-032 One sub-module irq_flag_bit (edge detect + set-dominant flag with write/clear) SHALL be instantiated five times.
REQ-033 Priority resolve and FSM SHALL live in irq_ctrl itself.

Verification
REQ-034 IE=0x05, pulse irq_src[2] -> IF=0xE4, wake=1, int_req=0 (IME=0).
REQ-035 ei, instr_done x2, IF=0x05, IE=0x1F -> int_req=1; dispatch -> vector=0x0040, IF=0xE4, IME=0.
REQ-036 Dispatch, wr_if=0x00 during W2 -> vector=0x0000 in JUMP, IF stays 0xE0.
REQ-037 irq_src[0] edge and wr_if=0x00 same clk -> IF=0xE1.
REQ-038 ei then di before second instr_done -> IME stays 0, int_req=0.
REQ-039 reset asserted in PUSH_HI with IF=0x08 -> IF=0xE0, disp_busy=0, vec_valid=0 at once.
